mul_result_writeback: RTL
=========================

Name: mul_result_writeback

Overview:
- Downstream stage of the 32x32 Booth multiplier. Accepts the signed 64-bit product through a valid/ready handshake and buffers it in a Z register plus one pending slot.
- Arbitrates for the shared 32-bit datapath bus and writes the low word into LO, then the high word into HI, over two granted bus cycles.
- Exposes HI/LO to mfhi/mflo and raises an interlock stall while a HI/LO update is still in flight.

Parameters:
- WIDTH, 32, datapath word width; the product is 2*WIDTH bits.

Ports:
- clk  in  1  rising-edge clock
- clr_n  in  1  synchronous active-low reset
- prod_valid  in  1  multiplier product valid
- prod_ready  out  1  block can accept a product this cycle
- prod  in  2*WIDTH  signed product {hi,lo}
- bus_req  out  1  request for the shared bus
- bus_gnt  in  1  bus granted this cycle
- bus_out  out  WIDTH  word driven to the bus; 0 when not driving
- lo_we  out  1  bus_out is the LO word this cycle (granted)
- hi_we  out  1  bus_out is the HI word this cycle (granted)
- rd_hi  in  1  mfhi request
- rd_lo  in  1  mflo request
- hilo_stall  out  1  stall the requesting instruction
- hi_q  out  WIDTH  HI register
- lo_q  out  WIDTH  LO register
- busy  out  1  any product buffered or being written

Behaviour:
- Reset: clock and reset are fixed; synchronous, active-low `clr_n` sampled on the rising edge of `clk`.
  - Clears hi_q and lo_q to 0, z_full and pend_full to 0, state to IDLE.
  - All outputs are 0 during reset; prod_ready is 0 while clr_n=0.
  - Reset mid-write discards buffered products. Any half-written HI/LO pair returns to 0.
- Handshake:
  - prod_ready = !pend_full.
  - A transfer occurs on a cycle with prod_valid && prod_ready.
  - prod is captured only on a transfer.
  - The producer must hold prod stable while prod_valid=1 and prod_ready=0.
- Buffer: Z register (2*WIDTH) plus one pending entry (2*WIDTH). Capture rules:
  - Z empty: the transfer loads Z.
  - Z full: the transfer loads pending.
  - Z released this cycle (HI write granted): Z loads from pending if pending is full; otherwise from the same-cycle transfer; otherwise Z empties. Pending then takes the same-cycle transfer if one exists.
  - No product is ever dropped or duplicated. Order is FIFO.
- FSM: states IDLE, WR_LO, WR_HI.
  - IDLE: go to WR_LO when z_full. A product captured at edge N gives WR_LO at N+1.
  - WR_LO: bus_req=1, bus_out=Z[WIDTH-1:0]. On bus_gnt: lo_we=1, lo_q<=Z low word, go to WR_HI. Without grant, hold state and keep driving.
  - WR_HI: bus_req=1, bus_out=Z[2W-1:W]. On bus_gnt: hi_we=1, hi_q<=Z high word, release Z. Go to WR_LO if Z is reloaded that edge, else IDLE.
  - bus_out is combinational from state and Z. It is 0 in IDLE and whenever bus_req=0.
- Latency with bus_gnt held at 1: transfer at edge N → lo_q valid after edge N+2, hi_q valid after edge N+3. Back-to-back products stream one per 2 cycles.
- Interlock:
  - hilo_stall = (rd_lo || rd_hi) && busy.
  - busy = z_full || pend_full.
  - hi_q and lo_q never change outside the WR_LO/WR_HI granted cycles.
- Width rules: no arithmetic. The product word split is exact, with no sign manipulation; HI holds bits [2W-1:W].

Decomposition:
- Shared package:
  - WIDTH default.
  - State encoding constants: IDLE=2'd0, WR_LO=2'd1, WR_HI=2'd2. Encoding 2'd3 is illegal and recovers to IDLE.
  - HI/LO bus-select codes used by the datapath's bus multiplexer.
- One natural sub-module, prod_skid_buf: the Z and pending two-entry buffer with valid/ready in and pop out. The FSM and HI/LO registers live in the top.

Test Plan:
- Reset, then one transfer of prod = 2*5 = 64'h0000_0000_0000_000A with bus_gnt=1 → lo_we at N+1 with bus_out=32'h0000000A; hi_we at N+2 with bus_out=0; lo_q=32'h0000000A, hi_q=0; busy drops after N+2.
- prod = -2*5 = 64'hFFFF_FFFF_FFFF_FFF6 → lo_q=32'hFFFFFFF6, hi_q=32'hFFFFFFFF.
- bus_gnt held 0 for 5 cycles in WR_LO → bus_req=1, bus_out stable, lo_q unchanged. Raise gnt → normal completion.
- Three back-to-back valid products with gnt=1:
  - prod_ready drops while the pending slot is full.
  - All three HI/LO pairs are written in order; none lost.
  - The same-cycle release-and-accept case is exercised.
- rd_lo=1 while busy → hilo_stall=1 until the final HI write edge, then 0.
- clr_n=0 during WR_HI with pending full → next cycle everything is 0 and prod_ready=1 after reset deasserts.

Source files
------------

// File: rtl/mul_result_writeback_pkg.sv
// ---------------------------------------------------------------------------
// mul_result_writeback_pkg
// Shared definitions for the multiplier result write-back stage:
//   DEF_WIDTH   - default datapath word width (product is 2*DEF_WIDTH bits)
//   wb_state_e  - write-back FSM state encoding (2'd3 is illegal)
//   bus_sel_e   - HI/LO select code for the datapath bus multiplexer
// ---------------------------------------------------------------------------
package mul_result_writeback_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } wb_state_e;

  typedef enum logic {
    BUS_SEL_LO = 1'b0,
    BUS_SEL_HI = 1'b1
  } bus_sel_e;

endpackage

// File: rtl/mul_result_writeback_prod_skid_buf.sv
// ---------------------------------------------------------------------------
// prod_skid_buf
// Two-entry FIFO holding multiplier products: the Z register (head, being
// written back) and one pending slot behind it.
// Ports:
//   clk, i_clr_n            - clock, synchronous active-low reset
//   i_in_valid/o_in_ready   - producer handshake, i_in_data is the product
//   i_pop                   - head of Z is consumed this cycle
//   o_z_data, o_z_full      - head entry and its valid flag
//   o_pend_full             - pending slot occupied
//   o_z_reload              - Z stays full across a pop (refilled that edge)
// ---------------------------------------------------------------------------
module prod_skid_buf
  import mul_result_writeback_pkg::*;
#(
  parameter int DW = 2 * DEF_WIDTH
) (
  input  logic          clk,
  input  logic          i_clr_n,
  input  logic          i_in_valid,
  input  logic [DW-1:0] i_in_data,
  output logic          o_in_ready,
  input  logic          i_pop,
  output logic [DW-1:0] o_z_data,
  output logic          o_z_full,
  output logic          o_pend_full,
  output logic          o_z_reload
);

  logic [DW-1:0] r_z;
  logic [DW-1:0] r_pend;
  logic          r_z_full;
  logic          r_pend_full;
  logic          w_fire;
  logic          w_pop;

  // Ready is suppressed during reset so nothing is accepted in that cycle.
  assign o_in_ready  = i_clr_n && !r_pend_full;
  assign w_fire      = i_in_valid && o_in_ready;
  assign w_pop       = i_pop && r_z_full;
  assign o_z_data    = r_z;
  assign o_z_full    = r_z_full;
  assign o_pend_full = r_pend_full;
  // On a pop the head refills from pending first, else from the incoming transfer.
  assign o_z_reload  = w_pop && (r_pend_full || w_fire);

  always_ff @(posedge clk) begin
    if (!i_clr_n) begin
      r_z         <= '0;
      r_pend      <= '0;
      r_z_full    <= 1'b0;
      r_pend_full <= 1'b0;
    end else if (w_pop) begin
      if (r_pend_full) begin
        r_z         <= r_pend;
        r_pend_full <= w_fire;
        if (w_fire) begin
          r_pend <= i_in_data;
        end
      end else if (w_fire) begin
        r_z <= i_in_data;
      end else begin
        r_z_full <= 1'b0;
      end
    end else if (w_fire) begin
      if (!r_z_full) begin
        r_z      <= i_in_data;
        r_z_full <= 1'b1;
      end else begin
        r_pend      <= i_in_data;
        r_pend_full <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_result_writeback.sv
// ---------------------------------------------------------------------------
// mul_result_writeback
// Takes signed 2*WIDTH-bit products from the multiplier, buffers them and
// writes LO then HI over two granted cycles of the shared datapath bus.
// Ports:
//   clk, clr_n              - clock, synchronous active-low reset
//   prod_valid/prod_ready   - product handshake, prod = {hi, lo}
//   bus_req/bus_gnt         - shared bus arbitration
//   bus_out                 - word driven onto the bus (0 when not driving)
//   lo_we/hi_we             - granted LO / HI write this cycle
//   rd_hi/rd_lo             - mfhi / mflo requests
//   hilo_stall              - interlock while an update is in flight
//   hi_q/lo_q               - HI / LO architectural registers
//   busy                    - any product buffered or being written
// ---------------------------------------------------------------------------
module mul_result_writeback
  import mul_result_writeback_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               prod_valid,
  output logic               prod_ready,
  input  logic [2*WIDTH-1:0] prod,
  output logic               bus_req,
  input  logic               bus_gnt,
  output logic [WIDTH-1:0]   bus_out,
  output logic               lo_we,
  output logic               hi_we,
  input  logic               rd_hi,
  input  logic               rd_lo,
  output logic               hilo_stall,
  output logic [WIDTH-1:0]   hi_q,
  output logic [WIDTH-1:0]   lo_q,
  output logic               busy
);

  wb_state_e          r_state;
  wb_state_e          w_state_next;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [2*WIDTH-1:0] w_z;
  logic               w_z_full;
  logic               w_pend_full;
  logic               w_z_reload;
  logic               w_pop;
  logic               w_drive;
  logic               w_lo_wr;
  logic               w_hi_wr;
  bus_sel_e           w_bus_sel;

  prod_skid_buf #(
    .DW (2 * WIDTH)
  ) u_skid (
    .clk         (clk),
    .i_clr_n     (clr_n),
    .i_in_valid  (prod_valid),
    .i_in_data   (prod),
    .o_in_ready  (prod_ready),
    .i_pop       (w_pop),
    .o_z_data    (w_z),
    .o_z_full    (w_z_full),
    .o_pend_full (w_pend_full),
    .o_z_reload  (w_z_reload)
  );

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_drive      = 1'b0;
    w_lo_wr      = 1'b0;
    w_hi_wr      = 1'b0;
    w_bus_sel    = BUS_SEL_LO;
    case (r_state)
      IDLE: begin
        if (w_z_full) begin
          w_state_next = WR_LO;
        end
      end
      WR_LO: begin
        w_drive   = 1'b1;
        w_bus_sel = BUS_SEL_LO;
        if (bus_gnt) begin
          w_lo_wr      = 1'b1;
          w_state_next = WR_HI;
        end
      end
      WR_HI: begin
        w_drive   = 1'b1;
        w_bus_sel = BUS_SEL_HI;
        if (bus_gnt) begin
          w_hi_wr      = 1'b1;
          w_pop        = 1'b1;
          // Stream straight into the next product when Z refills on this edge.
          w_state_next = w_z_reload ? WR_LO : IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_state <= IDLE;
      r_lo    <= '0;
      r_hi    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_lo_wr) begin
        r_lo <= w_z[WIDTH-1:0];
      end
      if (w_hi_wr) begin
        r_hi <= w_z[2*WIDTH-1:WIDTH];
      end
    end
  end

  // Outputs are forced quiet while reset is asserted.
  assign bus_req    = clr_n && w_drive;
  assign lo_we      = clr_n && w_lo_wr;
  assign hi_we      = clr_n && w_hi_wr;
  assign bus_out    = !bus_req ? '0 :
                      (w_bus_sel == BUS_SEL_HI) ? w_z[2*WIDTH-1:WIDTH] : w_z[WIDTH-1:0];
  assign busy       = clr_n && (w_z_full || w_pend_full);
  assign hilo_stall = (rd_lo || rd_hi) && busy;
  assign hi_q       = r_hi;
  assign lo_q       = r_lo;

endmodule
